// File: rtl/pipeline_ctrl_pkg.sv
// Shared RV32I decode constants: opcode-class and exception bit positions, controller FSM encoding.
// Constants only; no logic, no latency, no backpressure.
package pipeline_ctrl_pkg;

  localparam int OPCODE_WIDTH    = 8;
  localparam int EXCEPTION_WIDTH = 4;
  localparam int REG_COUNT       = 32;
  localparam int REG_AW          = 5;

  // one-hot opcode classes
  localparam int OPC_OP     = 0;
  localparam int OPC_OPIMM  = 1;
  localparam int OPC_LOAD   = 2;
  localparam int OPC_STORE  = 3;
  localparam int OPC_BRANCH = 4;
  localparam int OPC_JUMP   = 5;
  localparam int OPC_UPPER  = 6;
  localparam int OPC_SYSTEM = 7;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD_MASK = OPCODE_WIDTH'(1) << OPC_LOAD;

  localparam int EXC_ILLEGAL = 0;
  localparam int EXC_ECALL   = 1;
  localparam int EXC_EBREAK  = 2;
  localparam int EXC_MRET    = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_TRAP     = 2'd2,
    S_WAIT_ACK = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// Pending-load register scoreboard with same-cycle writeback bypass on lookups and empty flag.
// Set/clear take effect at the next edge; lookups are combinational; no backpressure.
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              set_vld,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_vld,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic              empty
);

  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] clr_mask;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] live;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_vld)
      clr_mask[clr_rd] = 1'b1;
    if (set_vld && set_rd != '0)
      set_mask[set_rd] = 1'b1;
    // a writeback this cycle already releases its register
    live     = pending & ~clr_mask;
    rs1_busy = live[rs1];
    rs2_busy = live[rs2];
    rd_busy  = live[rd];
    empty    = (live == '0);
  end

  // set is OR-ed after the clear so a same-register set wins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      pending <= '0;
    else
      pending <= (live | set_mask) & ~REG_COUNT'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Decode-stage pipeline controller: load-use stalls, redirect flush, precise trap sequencing, stall counter.
// stall/flush combinational, trap_req registered; stall holds decode until hazard clears or trap completes.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       de_valid,
  input  logic [REG_AW-1:0]          de_rs1,
  input  logic [REG_AW-1:0]          de_rs2,
  input  logic [REG_AW-1:0]          de_rd,
  input  logic [OPCODE_WIDTH-1:0]    de_opcode_type,
  input  logic [EXCEPTION_WIDTH-1:0] de_exception,
  input  logic                       ex_redirect,
  input  logic                       ld_wb_valid,
  input  logic [REG_AW-1:0]          ld_wb_rd,
  input  logic                       trap_ack,
  output logic                       stall,
  output logic                       flush,
  output logic                       trap_req,
  output logic [EXCEPTION_WIDTH-1:0] trap_cause,
  output logic [31:0]                stall_cnt
);

  ctrl_state_e state, state_nxt;
  logic        capture_cause;
  logic        is_load;
  logic        de_fire;
  logic        hazard;
  logic        rs1_busy, rs2_busy, rd_busy, sb_empty;

  assign is_load = (de_opcode_type & OPC_LOAD_MASK) != '0;

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .set_vld  (de_fire && is_load),
    .set_rd   (de_rd),
    .clr_vld  (ld_wb_valid),
    .clr_rd   (ld_wb_rd),
    .rs1      (de_rs1),
    .rs2      (de_rs2),
    .rd       (de_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .empty    (sb_empty)
  );

  assign hazard   = de_valid && (rs1_busy || rs2_busy || (is_load && rd_busy));
  assign stall    = (hazard || state != S_IDLE) && !ex_redirect;
  assign flush    = ex_redirect || state == S_TRAP;
  assign de_fire  = de_valid && !stall && !flush;
  assign trap_req = (state == S_TRAP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    capture_cause = 1'b0;
    case (state)
      S_IDLE: begin
        if (de_valid && |de_exception && !ex_redirect) begin
          state_nxt     = S_DRAIN;
          capture_cause = 1'b1;
        end
      end
      S_DRAIN: begin
        // an older redirecting branch squashes the excepting instruction
        if (ex_redirect)
          state_nxt = S_IDLE;
        else if (sb_empty)
          state_nxt = S_TRAP;
      end
      S_TRAP:     state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (trap_ack) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      trap_cause <= '0;
    else if (capture_cause)
      trap_cause <= de_exception;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: load-use stall, x0, redirect, trap sequencing, reset abort.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        de_valid;
  logic [4:0]  de_rs1, de_rs2, de_rd;
  logic [7:0]  de_opcode_type;
  logic [3:0]  de_exception;
  logic        ex_redirect;
  logic        ld_wb_valid;
  logic [4:0]  ld_wb_rd;
  logic        trap_ack;
  logic        stall, flush, trap_req;
  logic [3:0]  trap_cause;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] OP_LOAD = 8'b0000_0100;
  localparam logic [7:0] OP_ALU  = 8'b0000_0001;
  localparam logic [7:0] OP_SYS  = 8'b1000_0000;

  pipeline_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .de_valid       (de_valid),
    .de_rs1         (de_rs1),
    .de_rs2         (de_rs2),
    .de_rd          (de_rd),
    .de_opcode_type (de_opcode_type),
    .de_exception   (de_exception),
    .ex_redirect    (ex_redirect),
    .ld_wb_valid    (ld_wb_valid),
    .ld_wb_rd       (ld_wb_rd),
    .trap_ack       (trap_ack),
    .stall          (stall),
    .flush          (flush),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic de_idle();
    de_valid       = 1'b0;
    de_rs1         = '0;
    de_rs2         = '0;
    de_rd          = '0;
    de_opcode_type = '0;
    de_exception   = '0;
  endtask

  task automatic de_drive(input logic [7:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [3:0] exc);
    de_valid       = 1'b1;
    de_opcode_type = opc;
    de_rs1         = rs1;
    de_rs2         = rs2;
    de_rd          = rd;
    de_exception   = exc;
  endtask

  initial begin
    rstn = 1'b0;
    de_idle();
    ex_redirect = 1'b0;
    ld_wb_valid = 1'b0;
    ld_wb_rd    = '0;
    trap_ack    = 1'b0;
    #3;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_trap_req", {31'd0, trap_req}, 32'd0);
    check("rst_cause", {28'd0, trap_cause}, 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    ex_redirect = 1'b1;
    #1;
    check("rst_redirect_flush", {31'd0, flush}, 32'd1);
    ex_redirect = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // load-use: LOAD x5 then ADD reading x5
    de_drive(OP_LOAD, 5'd0, 5'd0, 5'd5, 4'd0);
    #1 check("lu_load_nostall", {31'd0, stall}, 32'd0);
    tick();
    de_drive(OP_ALU, 5'd5, 5'd0, 5'd6, 4'd0);
    #1 check("lu_stall_c0", {31'd0, stall}, 32'd1);
    tick();
    check("lu_stall_c1", {31'd0, stall}, 32'd1);
    check("lu_cnt_1", stall_cnt, 32'd1);
    tick();
    ld_wb_valid = 1'b1;
    ld_wb_rd    = 5'd5;
    #1 check("lu_wb_bypass", {31'd0, stall}, 32'd0);
    check("lu_cnt_2", stall_cnt, 32'd2);
    tick();
    ld_wb_valid = 1'b0;
    de_idle();
    #1 check("lu_after", {31'd0, stall}, 32'd0);
    check("lu_cnt_hold", stall_cnt, 32'd2);

    // x0 is never pending
    de_drive(OP_LOAD, 5'd0, 5'd0, 5'd0, 4'd0);
    tick();
    de_drive(OP_ALU, 5'd0, 5'd0, 5'd1, 4'd0);
    #1 check("x0_nostall", {31'd0, stall}, 32'd0);
    tick();
    de_idle();
    check("x0_cnt", stall_cnt, 32'd2);

    // redirect with a concurrent rs2 hazard: flush wins and the LOAD must not set x9
    de_drive(OP_LOAD, 5'd0, 5'd0, 5'd3, 4'd0);
    tick();
    de_drive(OP_LOAD, 5'd0, 5'd3, 5'd9, 4'd0);
    ex_redirect = 1'b1;
    #1 check("rd_hz_flush", {31'd0, flush}, 32'd1);
    check("rd_hz_nostall", {31'd0, stall}, 32'd0);
    tick();
    ex_redirect = 1'b0;
    de_drive(OP_ALU, 5'd9, 5'd0, 5'd1, 4'd0);
    #1 check("rd_x9_free", {31'd0, stall}, 32'd0);
    de_drive(OP_ALU, 5'd0, 5'd3, 5'd1, 4'd0);
    #1 check("rd_x3_still_busy", {31'd0, stall}, 32'd1);
    de_idle();
    ld_wb_valid = 1'b1;
    ld_wb_rd    = 5'd3;
    tick();
    ld_wb_valid = 1'b0;
    check("rd_cnt", stall_cnt, 32'd2);

    // same-register set and clear in one cycle: set wins
    de_drive(OP_LOAD, 5'd0, 5'd0, 5'd4, 4'd0);
    tick();
    de_drive(OP_LOAD, 5'd0, 5'd0, 5'd4, 4'd0);
    ld_wb_valid = 1'b1;
    ld_wb_rd    = 5'd4;
    #1 check("waw_bypass", {31'd0, stall}, 32'd0);
    tick();
    ld_wb_valid = 1'b0;
    de_drive(OP_ALU, 5'd4, 5'd0, 5'd1, 4'd0);
    #1 check("set_wins", {31'd0, stall}, 32'd1);
    de_idle();
    ld_wb_valid = 1'b1;
    ld_wb_rd    = 5'd4;
    tick();
    ld_wb_valid = 1'b0;

    // ECALL while load x7 outstanding
    de_drive(OP_LOAD, 5'd0, 5'd0, 5'd7, 4'd0);
    tick();
    de_drive(OP_SYS, 5'd0, 5'd0, 5'd0, 4'b0010);
    #1 check("ec_pre_stall", {31'd0, stall}, 32'd0);
    tick();
    de_idle();
    #1 check("ec_drain_stall", {31'd0, stall}, 32'd1);
    check("ec_drain_noreq", {31'd0, trap_req}, 32'd0);
    tick();
    check("ec_drain_hold", {31'd0, trap_req}, 32'd0);
    check("ec_cnt_3", stall_cnt, 32'd3);
    ld_wb_valid = 1'b1;
    ld_wb_rd    = 5'd7;
    tick();
    ld_wb_valid = 1'b0;
    check("ec_trap_req", {31'd0, trap_req}, 32'd1);
    check("ec_trap_flush", {31'd0, flush}, 32'd1);
    check("ec_cause", {28'd0, trap_cause}, 32'h2);
    tick();
    check("ec_req_one_cycle", {31'd0, trap_req}, 32'd0);
    check("ec_wait_noflush", {31'd0, flush}, 32'd0);
    check("ec_wait_stall", {31'd0, stall}, 32'd1);
    tick();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check("ec_idle_stall", {31'd0, stall}, 32'd0);
    check("ec_cnt_7", stall_cnt, 32'd7);
    check("ec_cause_hold", {28'd0, trap_cause}, 32'h2);

    // ILLEGAL cancelled by redirect in DRAIN
    de_drive(OP_ALU, 5'd0, 5'd0, 5'd0, 4'b0001);
    tick();
    de_idle();
    ex_redirect = 1'b1;
    #1 check("il_flush", {31'd0, flush}, 32'd1);
    check("il_nostall", {31'd0, stall}, 32'd0);
    tick();
    ex_redirect = 1'b0;
    check("il_noreq", {31'd0, trap_req}, 32'd0);
    check("il_idle", {31'd0, stall}, 32'd0);
    tick();
    check("il_noreq_later", {31'd0, trap_req}, 32'd0);
    check("il_cnt", stall_cnt, 32'd7);
    check("il_cause", {28'd0, trap_cause}, 32'h1);

    // EBREAK to WAIT_ACK, redirect ignored there, then reset aborts the trap
    de_drive(OP_SYS, 5'd0, 5'd0, 5'd0, 4'b0100);
    tick();
    de_idle();
    tick();
    check("rs_trap_req", {31'd0, trap_req}, 32'd1);
    tick();
    ex_redirect = 1'b1;
    #1 check("rs_wait_redirect_nostall", {31'd0, stall}, 32'd0);
    tick();
    ex_redirect = 1'b0;
    #1 check("rs_wait_kept", {31'd0, stall}, 32'd1);
    rstn = 1'b0;
    #1 check("rs_async_stall", {31'd0, stall}, 32'd0);
    check("rs_async_cnt", stall_cnt, 32'd0);
    check("rs_async_cause", {28'd0, trap_cause}, 32'd0);
    check("rs_async_req", {31'd0, trap_req}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    tick();
    check("rs_post_req", {31'd0, trap_req}, 32'd0);
    check("rs_post_stall", {31'd0, stall}, 32'd0);
    check("rs_post_flush", {31'd0, flush}, 32'd0);
    check("rs_post_cnt", stall_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port de_valid, input, 1, the decode stage holds a valid instruction (decode clk_en).
REQ-004 SHALL have ports de_rs1 and de_rs2, input, 5 each, source register addresses of the decoded instruction.
REQ-005 SHALL have port de_rd, input, 5, destination register of the decoded instruction.
REQ-006 SHALL have port de_opcode_type, input, `OPCODE_WIDTH, one-hot opcode class from decode.
REQ-007 SHALL have port de_exception, input, `EXCEPTION_WIDTH, decode exception flags (ILLEGAL, ECALL, EBREAK, MRET).
REQ-008 SHALL have port ex_redirect, input, 1, the execute stage resolved a taken branch or jump.
REQ-009 SHALL have ports ld_wb_valid (input, 1) and ld_wb_rd (input, 5), meaning a load result is written to ld_wb_rd this cycle.
REQ-010 SHALL have port trap_ack, input, 1, the CSR unit has accepted the trap.
REQ-011 SHALL have port stall, output, 1, drives the decode stage prev_stall.
REQ-012 SHALL have port flush, output, 1, drives the decode stage prev_flush.
REQ-013 SHALL have ports trap_req (output, 1) and trap_cause (output, `EXCEPTION_WIDTH), the trap request to the CSR unit and its latched cause.
REQ-014 SHALL have port stall_cnt, output, 32, count of cycles with stall asserted.

Function
REQ-015 de_fire SHALL be de_valid && !stall && !flush.
REQ-016 Scoreboard SHALL be 32 pending bits; bit 0 is never set.
REQ-017 On de_fire with de_opcode_type[`LOAD] set and de_rd != 0, bit de_rd SHALL be set at the next edge.
REQ-018 On ld_wb_valid, bit ld_wb_rd SHALL be cleared at the next edge; if set and clear target the same register in the same cycle, set SHALL win.
REQ-019 A register SHALL count as busy when its pending bit is 1 and it is not being cleared by ld_wb_valid in the current cycle (same-cycle writeback bypass).
REQ-020 Hazard SHALL be de_valid && (busy(de_rs1) || busy(de_rs2) || (load && busy(de_rd))), with x0 never busy.
REQ-021 stall SHALL be combinational: (hazard || state != IDLE) && !ex_redirect.
REQ-022 flush SHALL be combinational: ex_redirect || state == TRAP.
REQ-023 FSM states SHALL be IDLE, DRAIN, TRAP and WAIT_ACK.
REQ-024 IDLE -> DRAIN SHALL occur when de_valid && |de_exception && !ex_redirect; de_exception SHALL be latched into trap_cause at that edge.
REQ-025 DRAIN -> TRAP SHALL occur when the scoreboard is all-zero (the same-cycle clear counts); otherwise the FSM SHALL stay in DRAIN.
REQ-026 In TRAP, trap_req SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_ACK.
REQ-027 WAIT_ACK -> IDLE SHALL occur on trap_ack; trap_cause SHALL hold its value until the next capture.
REQ-028 ex_redirect in DRAIN SHALL cancel the trap (the older instruction wins): next state IDLE, no trap_req; in TRAP or WAIT_ACK, ex_redirect SHALL be ignored by the FSM.
REQ-029 ex_redirect together with a hazard SHALL give flush=1 and stall=0; the decode instruction SHALL NOT set scoreboard bits.
REQ-030 stall_cnt SHALL increment by 1 in each cycle with stall=1 and saturate at 0xFFFF_FFFF.
REQ-031 trap_req SHALL be registered, i.e. decoded from the state register.

Reset
REQ-032 While rstn=0, the following SHALL hold asynchronously: state IDLE, scoreboard 0, trap_cause 0, stall_cnt 0; stall, flush and trap_req SHALL be 0 unless ex_redirect drives flush.
REQ-033 Reset asserted mid-DRAIN or mid-WAIT_ACK SHALL abandon the trap with no trap_req after release.

Structure
REQ-034 `OPCODE_WIDTH, `EXCEPTION_WIDTH, the `LOAD index, exception bit indices and FSM state encodings SHALL live in the shared header rv32i_header.vh.
REQ-035 The scoreboard (set, clear, busy lookup, empty flag) SHALL be the sub-module hazard_scoreboard; the FSM and counter SHALL stay in pipeline_ctrl.

Verification
REQ-036 Scenario: LOAD rd=5 fires, then ADD rs1=5 is at decode -> stall=1 until ld_wb_valid with rd=5; stall=0 in the writeback cycle; stall_cnt increases by the stall cycles.
REQ-037 Scenario: LOAD rd=0 fires, then rs1=0 -> no scoreboard bit set, stall never asserted.
REQ-038 Scenario: ECALL (de_exception=0010) with load rd=7 outstanding -> state DRAIN, stall=1; ld_wb rd=7 -> TRAP with trap_req=1 and flush=1 for one cycle, trap_cause=0010; trap_ack -> IDLE.
REQ-039 Scenario: ILLEGAL enters DRAIN, then ex_redirect=1 -> flush=1, state IDLE, trap_req never asserted.
REQ-040 Scenario: hazard on rs2=3 concurrent with ex_redirect -> flush=1, stall=0, scoreboard unchanged.
REQ-041 Scenario: rstn pulled low during WAIT_ACK -> all outputs 0 immediately; after release, IDLE with stall_cnt=0.
